// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency results
// are buffered in a small FIFO and drained into free slots or forced through after starvation.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lo_valid,
    output logic        lo_ready,
    input  logic [4:0]  lo_wa,
    input  logic [31:0] lo_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    output logic [31:0] busy,
    output logic        stall_wb,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic [4:0]    fifo_wa [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          nonempty;
    logic          pipe_eff;
    logic          pop;
    logic          push;
    logic [4:0]    head_wa;
    logic [31:0]   head_wd;
    logic [31:0]   busy_nxt;

    always_comb begin
        nonempty = (count != '0);
        pipe_eff = pipe_we && (pipe_wa != 5'd0);
        pop      = nonempty && (stall_wb || !pipe_eff);
        lo_ready = !reset && (count < DEPTH_C);
        // x0 results complete the handshake but are never stored
        push     = lo_valid && lo_ready && (lo_wa != 5'd0);
        head_wa  = fifo_wa[rd_ptr];
        head_wd  = fifo_wd[rd_ptr];
    end

    always_comb begin
        we3 = 1'b0;
        wa3 = 5'd0;
        wd3 = 32'd0;
        if (!reset && pop) begin
            we3 = 1'b1;
            wa3 = head_wa;
            wd3 = head_wd;
        end else if (!reset && pipe_eff) begin
            we3 = 1'b1;
            wa3 = pipe_wa;
            wd3 = pipe_wd;
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (pop)
            busy_nxt[head_wa] = 1'b0;
        // a same-cycle issue to the drained register must win
        if (iss_valid && (iss_wa != 5'd0))
            busy_nxt[iss_wa] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= lo_wa;
            fifo_wd[wr_ptr] <= lo_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            busy       <= '0;
            starve_cnt <= '0;
            stall_wb   <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (!nonempty || pop) begin
                starve_cnt <= '0;
                stall_wb   <= 1'b0;
            end else if (starve_cnt == STARVE_LAST) begin
                starve_cnt <= '0;
                stall_wb   <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + SW'(1);
                stall_wb   <= 1'b0;
            end
        end
    end
endmodule
